array_access_sched: RTL and testbench
=====================================

Name: array_access_sched

Overview:
- Scheduler and controller in front of a 512x13 1R1W predictor-table SRAM macro wrapper.
- After reset or flush it sweeps the whole array to INIT_VALUE.
- In normal operation it arbitrates two write requesters (training update, allocation) onto the single write port and issues reads.
- Provides same-cycle read/write forwarding and holds read data stable between reads, so behaviour does not depend on the macro.

Parameters:
- DEPTH, 512, number of entries.
- ADDR_W, 9, address width (log2 DEPTH).
- DATA_W, 13, entry width.
- INIT_VALUE, 0, value written to every entry during the sweep.
- CNT_W, 16, width of the allocation-stall counter.

Ports:
- clock  in  1  sole clock; the SRAM read and write clocks are tied to it.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  request to re-initialise the array; honoured only in RUN.
- init_done  out  1  high in RUN.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid && rd_ready.
- rd_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  one-cycle pulse, the cycle after an accepted read.
- rd_data  out  DATA_W  read data, held between reads.
- upd_valid, upd_ready, upd_addr, upd_data  in/out/in/in  1/1/ADDR_W/DATA_W  high-priority write requester.
- alc_valid, alc_ready, alc_addr, alc_data  in/out/in/in  1/1/ADDR_W/DATA_W  low-priority write requester.
- alc_stall_cnt  out  CNT_W  saturating count of cycles with alc_valid && !alc_ready while in RUN.
- mem_r_en, mem_r_addr  out  1/ADDR_W  to SRAM read port.
- mem_r_data  in  DATA_W  from SRAM; valid the cycle after mem_r_en.
- mem_w_en, mem_w_addr, mem_w_data  out  1/ADDR_W/DATA_W  to SRAM write port.

Behaviour:
- FSM states: INIT, RUN.
- Reset forces INIT, init_ptr=0, rd_resp_valid=0, rd_data hold reg=0, alc_stall_cnt=0.
- While reset_n=0, mem_r_en and mem_w_en are 0.
- INIT, every cycle:
  - mem_w_en=1, mem_w_addr=init_ptr, mem_w_data=INIT_VALUE, init_ptr++.
  - When init_ptr==DEPTH-1, the next state is RUN and init_ptr wraps to 0.
  - The sweep takes exactly DEPTH cycles.
  - rd_ready, upd_ready, alc_ready and init_done are all 0. flush is ignored.
- RUN:
  - init_done=1, rd_ready=1, upd_ready=1, alc_ready=!upd_valid.
  - Write grant: upd if upd_valid, else alc if alc_valid. mem_w_* is driven combinationally from the granted requester; mem_w_en=0 when nothing is granted.
  - Read: an accepted read drives mem_r_en=1 and mem_r_addr=rd_addr in the same cycle.
- flush in RUN:
  - Next state is INIT with init_ptr=0.
  - Write requests in the flush cycle are still granted.
  - A read accepted in the flush cycle still produces its response in the next cycle.
- Read response:
  - rd_resp_valid_q <= accepted read.
  - If an accepted read and a granted write target the same address in the same cycle, latch fwd_q=1 and fwd_data_q=write data (write-first semantics).
  - In the response cycle, rd_data = fwd_q ? fwd_data_q : mem_r_data, and the hold register captures that value.
  - In all other cycles rd_data = hold register. A write to the same address after the read cycle does not change rd_data.
  - Read latency is one cycle. Back-to-back reads are supported: one per cycle, each with its own response.
- alc_stall_cnt increments when RUN && alc_valid && upd_valid, and saturates at all-ones. It is cleared only by reset, not by flush.
- Reset mid-INIT or mid-RUN: the sweep restarts from address 0 and any pending response is dropped.

Decomposition:
- Shared package:
  - State enum {INIT, RUN}.
  - DEPTH, ADDR_W, DATA_W defaults.
  - A write-request struct {valid, addr, data} used by both requesters and the mem write bus.
- One natural sub-module: array_wr_arb, the fixed-priority two-requester write arbiter with the init override. It is combinational apart from the stall counter.

Test Plan:
- Reset release → mem_w_en=1 for exactly 512 cycles, addresses 0..511, data 0. init_done rises on cycle 513. rd/upd/alc ready stay 0 throughout the sweep.
- After init: upd write addr 5 data 0x1ABC, then a read of addr 5 two cycles later → rd_resp_valid pulse with rd_data=0x1ABC. rd_data still 0x1ABC ten idle cycles later, even after a write of 0x0001 to addr 5.
- Same cycle: read addr 7 and upd write addr 7 data 0x0F0F, with the SRAM model returning stale 0 → rd_data=0x0F0F in the response cycle.
- upd_valid and alc_valid both held for 3 cycles → upd granted each cycle, alc_ready=0, alc_stall_cnt=3. upd drops → alc granted the next cycle.
- Read accepted in the flush cycle → response delivered the next cycle. mem_w then sweeps 0..511 with INIT_VALUE, and a later read of any address returns 0.
- reset_n pulsed low at sweep address 200 → the sweep restarts at 0 and completes a full 512 cycles. rd_data=0 and alc_stall_cnt=0.

Source files
------------

// File: rtl/array_access_sched_pkg.sv
// Shared types and default geometry for the predictor-table access scheduler.
// The write-request struct is common to both requesters and the SRAM write bus.
package array_access_sched_pkg;

    localparam int TBL_DEPTH  = 512;
    localparam int TBL_ADDR_W = 9;
    localparam int TBL_DATA_W = 13;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [TBL_ADDR_W-1:0] addr;
        logic [TBL_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/array_wr_arb.sv
// Fixed-priority write arbiter: init sweep overrides everything, then the
// training update beats allocation. Also keeps the allocation stall counter.
module array_wr_arb
    import array_access_sched_pkg::*;
#(
    parameter logic [TBL_DATA_W-1:0] INIT_VALUE = '0,
    parameter int                    CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [TBL_ADDR_W-1:0] init_ptr,
    input  wr_req_t               upd,
    input  wr_req_t               alc,
    output wr_req_t               mem_w,
    output logic                  upd_ready,
    output logic                  alc_ready,
    output logic [CNT_W-1:0]      alc_stall_cnt
);

    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        mem_w     = '0;
        upd_ready = 1'b0;
        alc_ready = 1'b0;
        if (!reset_n) begin
            mem_w = '0;
        end else if (!run) begin
            mem_w.valid = 1'b1;
            mem_w.addr  = init_ptr;
            mem_w.data  = INIT_VALUE;
        end else begin
            upd_ready = 1'b1;
            alc_ready = !upd.valid;
            if (upd.valid) begin
                mem_w = upd;
            end else if (alc.valid) begin
                mem_w = alc;
            end
        end
    end

    // Saturates rather than wraps so a long starvation stays visible.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (run && upd.valid && alc.valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign alc_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/array_access_sched.sv
// Scheduler in front of a 1R1W predictor-table SRAM: init sweep, write
// arbitration, and a one-cycle read path with write-first forwarding.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_INIT | sweeping every entry to INIT_VALUE, all requesters held off
//   ST_RUN  | normal operation, reads and arbitrated writes accepted
module array_access_sched
    import array_access_sched_pkg::*;
#(
    parameter int                DEPTH      = TBL_DEPTH,
    parameter int                ADDR_W     = TBL_ADDR_W,
    parameter int                DATA_W     = TBL_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    output logic              init_done,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              alc_valid,
    output logic              alc_ready,
    input  logic [ADDR_W-1:0] alc_addr,
    input  logic [DATA_W-1:0] alc_data,
    output logic [CNT_W-1:0]  alc_stall_cnt,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              init_last;
    logic              run;
    logic              rd_acc;
    logic              resp_q;
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] hold_q;
    wr_req_t           upd_req, alc_req, mem_w;

    assign init_last = (init_ptr_q == ADDR_W'(DEPTH - 1));
    assign run       = (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                if (init_last) begin
                    state_d    = ST_RUN;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_ptr_d = '0;
            end
        endcase
    end

    assign upd_req = '{valid: upd_valid, addr: upd_addr, data: upd_data};
    assign alc_req = '{valid: alc_valid, addr: alc_addr, data: alc_data};

    array_wr_arb #(
        .INIT_VALUE (INIT_VALUE),
        .CNT_W      (CNT_W)
    ) u_wr_arb (
        .clock         (clock),
        .reset_n       (reset_n),
        .run           (run),
        .init_ptr      (init_ptr_q),
        .upd           (upd_req),
        .alc           (alc_req),
        .mem_w         (mem_w),
        .upd_ready     (upd_ready),
        .alc_ready     (alc_ready),
        .alc_stall_cnt (alc_stall_cnt)
    );

    assign mem_w_en   = mem_w.valid;
    assign mem_w_addr = mem_w.addr;
    assign mem_w_data = mem_w.data;

    assign init_done  = run;
    assign rd_ready   = run && reset_n;
    assign rd_acc     = rd_valid && rd_ready;
    assign mem_r_en   = rd_acc;
    assign mem_r_addr = rd_addr;

    // Response data comes from the forward latch or the macro exactly once,
    // then is replayed from the hold register until the next response.
    always_comb begin
        rd_data = hold_q;
        if (resp_q) begin
            rd_data = fwd_q ? fwd_data_q : mem_r_data;
        end
    end

    assign rd_resp_valid = resp_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            resp_q     <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            resp_q     <= rd_acc;
            fwd_q      <= rd_acc && mem_w.valid && (mem_w.addr == rd_addr);
            fwd_data_q <= mem_w.data;
            if (resp_q) begin
                hold_q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_array_access_sched.sv
// Directed bench for array_access_sched with a behavioural 1R1W SRAM that
// returns the pre-write (stale) value on a same-cycle read/write collision.
module tb_array_access_sched;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        init_done;
    logic        rd_valid;
    logic        rd_ready;
    logic [8:0]  rd_addr;
    logic        rd_resp_valid;
    logic [12:0] rd_data;
    logic        upd_valid;
    logic        upd_ready;
    logic [8:0]  upd_addr;
    logic [12:0] upd_data;
    logic        alc_valid;
    logic        alc_ready;
    logic [8:0]  alc_addr;
    logic [12:0] alc_data;
    logic [15:0] alc_stall_cnt;
    logic        mem_r_en;
    logic [8:0]  mem_r_addr;
    logic [12:0] mem_r_data;
    logic        mem_w_en;
    logic [8:0]  mem_w_addr;
    logic [12:0] mem_w_data;

    logic [12:0] sram [0:511];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_r_en) mem_r_data <= sram[mem_r_addr];
        if (mem_w_en) sram[mem_w_addr] <= mem_w_data;
    end

    array_access_sched dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .flush         (flush),
        .init_done     (init_done),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_data       (rd_data),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_addr      (upd_addr),
        .upd_data      (upd_data),
        .alc_valid     (alc_valid),
        .alc_ready     (alc_ready),
        .alc_addr      (alc_addr),
        .alc_data      (alc_data),
        .alc_stall_cnt (alc_stall_cnt),
        .mem_r_en      (mem_r_en),
        .mem_r_addr    (mem_r_addr),
        .mem_r_data    (mem_r_data),
        .mem_w_en      (mem_w_en),
        .mem_w_addr    (mem_w_addr),
        .mem_w_data    (mem_w_data)
    );

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        flush     = 1'b0;
        rd_valid  = 1'b0;
        upd_valid = 1'b0;
        alc_valid = 1'b0;
    endtask

    // Caller is positioned just after the edge that starts sweep address 0.
    task automatic run_sweep(input string tag, input int last);
        for (int i = 0; i <= last; i++) begin
            if (i > 0) cyc;
            @(negedge clock);
            checks++;
            if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 9'(i), 13'h0}) begin
                errors++;
                $display("FAIL %s_wr[%0d]: got en=%b addr=%0d data=%h, expected en=1 addr=%0d data=0",
                         tag, i, mem_w_en, mem_w_addr, mem_w_data, i);
            end
            checks++;
            if ({init_done, rd_ready, upd_ready, alc_ready, mem_r_en} !== 5'b0) begin
                errors++;
                $display("FAIL %s_ready[%0d]: got done/rd/upd/alc/ren=%b, expected 00000",
                         tag, i, {init_done, rd_ready, upd_ready, alc_ready, mem_r_en});
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle;
        rd_addr = '0; upd_addr = '0; upd_data = '0; alc_addr = '0; alc_data = '0;
        repeat (3) cyc;
        @(negedge clock);
        checks++;
        if ({mem_w_en, mem_r_en, init_done, rd_resp_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got wen/ren/done/resp=%b, expected 0000",
                     {mem_w_en, mem_r_en, init_done, rd_resp_valid});
        end
        checks++;
        if (rd_data !== 13'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h, expected 0", rd_data);
        end
        checks++;
        if (alc_stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d, expected 0", alc_stall_cnt);
        end
    endtask

    task automatic test_init_sweep;
        cyc;
        reset_n   = 1'b1;
        flush     = 1'b1;
        rd_valid  = 1'b1; rd_addr  = 9'd3;
        upd_valid = 1'b1; upd_addr = 9'd4; upd_data = 13'h1111;
        alc_valid = 1'b1; alc_addr = 9'd6; alc_data = 13'h0222;
        run_sweep("init", 511);
        cyc;
        idle;
        @(negedge clock);
        checks++;
        if ({init_done, rd_ready, upd_ready, alc_ready, mem_w_en} !== 5'b11110) begin
            errors++;
            $display("FAIL init_done_513: got done/rd/upd/alc/wen=%b, expected 11110",
                     {init_done, rd_ready, upd_ready, alc_ready, mem_w_en});
        end
        checks++;
        if (alc_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL init_no_stall: got %0d, expected 0", alc_stall_cnt);
        end
    endtask

    task automatic test_upd_read;
        cyc;
        upd_valid = 1'b1; upd_addr = 9'd5; upd_data = 13'h1ABC;
        @(negedge clock);
        checks++;
        if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 9'd5, 13'h1ABC}) begin
            errors++;
            $display("FAIL upd_write: got en=%b addr=%0d data=%h, expected 1/5/1abc",
                     mem_w_en, mem_w_addr, mem_w_data);
        end
        cyc; idle;
        cyc;
        rd_valid = 1'b1; rd_addr = 9'd5;
        @(negedge clock);
        checks++;
        if ({rd_ready, mem_r_en, mem_r_addr} !== {1'b1, 1'b1, 9'd5}) begin
            errors++;
            $display("FAIL read_issue: got rdy=%b ren=%b raddr=%0d, expected 1/1/5",
                     rd_ready, mem_r_en, mem_r_addr);
        end
        cyc; idle;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h1ABC}) begin
            errors++;
            $display("FAIL read_resp: got valid=%b data=%h, expected 1/1abc", rd_resp_valid, rd_data);
        end
        cyc;
        upd_valid = 1'b1; upd_addr = 9'd5; upd_data = 13'h0001;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b0, 13'h1ABC}) begin
            errors++;
            $display("FAIL read_hold_after_wr: got valid=%b data=%h, expected 0/1abc", rd_resp_valid, rd_data);
        end
        cyc; idle;
        repeat (9) cyc;
        @(negedge clock);
        checks++;
        if (rd_data !== 13'h1ABC) begin
            errors++;
            $display("FAIL read_hold_idle: got %h, expected 1abc", rd_data);
        end
    endtask

    task automatic test_forward;
        cyc;
        rd_valid  = 1'b1; rd_addr  = 9'd7;
        upd_valid = 1'b1; upd_addr = 9'd7; upd_data = 13'h0F0F;
        cyc; idle;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0F0F}) begin
            errors++;
            $display("FAIL fwd_same_addr: got valid=%b data=%h, expected 1/0f0f", rd_resp_valid, rd_data);
        end
        cyc;
        rd_valid  = 1'b1; rd_addr  = 9'd9;
        alc_valid = 1'b1; alc_addr = 9'd8; alc_data = 13'h0123;
        @(negedge clock);
        checks++;
        if ({alc_ready, mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 1'b1, 9'd8, 13'h0123}) begin
            errors++;
            $display("FAIL alc_alone: got rdy=%b en=%b addr=%0d data=%h, expected 1/1/8/0123",
                     alc_ready, mem_w_en, mem_w_addr, mem_w_data);
        end
        cyc;
        idle;
        rd_valid = 1'b1; rd_addr = 9'd8;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0}) begin
            errors++;
            $display("FAIL no_fwd_diff_addr: got valid=%b data=%h, expected 1/0000", rd_resp_valid, rd_data);
        end
        cyc; idle;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0123}) begin
            errors++;
            $display("FAIL alc_readback: got valid=%b data=%h, expected 1/0123", rd_resp_valid, rd_data);
        end
    endtask

    task automatic test_arb;
        logic [12:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            cyc;
            exp_d     = 13'h100 + 13'(i);
            upd_valid = 1'b1; upd_addr = 9'(10 + i); upd_data = exp_d;
            alc_valid = 1'b1; alc_addr = 9'd20;      alc_data = 13'h0AAA;
            @(negedge clock);
            checks++;
            if ({upd_ready, alc_ready, mem_w_en, mem_w_addr, mem_w_data} !== {2'b10, 1'b1, 9'(10 + i), exp_d}) begin
                errors++;
                $display("FAIL arb_upd_wins[%0d]: got urdy=%b ardy=%b en=%b addr=%0d data=%h, expected 1/0/1/%0d/%h",
                         i, upd_ready, alc_ready, mem_w_en, mem_w_addr, mem_w_data, 10 + i, exp_d);
            end
        end
        cyc;
        upd_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({alc_ready, mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 1'b1, 9'd20, 13'h0AAA}) begin
            errors++;
            $display("FAIL arb_alc_after: got rdy=%b en=%b addr=%0d data=%h, expected 1/1/20/0aaa",
                     alc_ready, mem_w_en, mem_w_addr, mem_w_data);
        end
        checks++;
        if (alc_stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, expected 3", alc_stall_cnt);
        end
        cyc;
        idle;
        rd_valid = 1'b1; rd_addr = 9'd12;
        cyc;
        rd_addr = 9'd20;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data, mem_r_en, mem_r_addr} !== {1'b1, 13'h0102, 1'b1, 9'd20}) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b data=%h ren=%b raddr=%0d, expected 1/0102/1/20",
                     rd_resp_valid, rd_data, mem_r_en, mem_r_addr);
        end
        cyc; idle;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0AAA}) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b data=%h, expected 1/0aaa", rd_resp_valid, rd_data);
        end
    endtask

    task automatic test_flush;
        cyc;
        upd_valid = 1'b1; upd_addr = 9'd30; upd_data = 13'h0155;
        cyc; idle;
        cyc;
        flush     = 1'b1;
        rd_valid  = 1'b1; rd_addr  = 9'd30;
        upd_valid = 1'b1; upd_addr = 9'd31; upd_data = 13'h0077;
        @(negedge clock);
        checks++;
        if ({init_done, mem_r_en, mem_w_en, mem_w_addr, mem_w_data} !== {3'b111, 9'd31, 13'h0077}) begin
            errors++;
            $display("FAIL flush_cycle: got done=%b ren=%b wen=%b addr=%0d data=%h, expected 1/1/1/31/0077",
                     init_done, mem_r_en, mem_w_en, mem_w_addr, mem_w_data);
        end
        cyc; idle;
        #2;
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0155}) begin
            errors++;
            $display("FAIL flush_read_resp: got valid=%b data=%h, expected 1/0155", rd_resp_valid, rd_data);
        end
        checks++;
        if (alc_stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL flush_keeps_cnt: got %0d, expected 3", alc_stall_cnt);
        end
        run_sweep("flush", 511);
        cyc;
        rd_valid = 1'b1; rd_addr = 9'd31;
        @(negedge clock);
        checks++;
        if ({init_done, mem_r_en} !== 2'b11) begin
            errors++;
            $display("FAIL flush_back_run: got done=%b ren=%b, expected 1/1", init_done, mem_r_en);
        end
        cyc; idle;
        @(negedge clock);
        checks++;
        if ({rd_resp_valid, rd_data} !== {1'b1, 13'h0}) begin
            errors++;
            $display("FAIL flush_cleared: got valid=%b data=%h, expected 1/0000", rd_resp_valid, rd_data);
        end
    endtask

    task automatic test_reset_mid;
        cyc;
        upd_valid = 1'b1; upd_addr = 9'd40; upd_data = 13'h1234;
        cyc; idle;
        rd_valid = 1'b1; rd_addr = 9'd40;
        cyc; idle;
        @(negedge clock);
        checks++;
        if (rd_data !== 13'h1234) begin
            errors++;
            $display("FAIL pre_reset_data: got %h, expected 1234", rd_data);
        end
        cyc;
        flush = 1'b1;
        cyc; idle;
        run_sweep("mid", 200);
        cyc;
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_w_en, mem_r_en} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gates_mem: got wen=%b ren=%b, expected 0/0", mem_w_en, mem_r_en);
        end
        cyc;
        reset_n = 1'b1;
        run_sweep("rst", 511);
        cyc;
        @(negedge clock);
        checks++;
        if ({init_done, rd_data} !== {1'b1, 13'h0}) begin
            errors++;
            $display("FAIL post_reset_run: got done=%b data=%h, expected 1/0000", init_done, rd_data);
        end
        checks++;
        if (alc_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d, expected 0", alc_stall_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_init_sweep;
        test_upd_read;
        test_forward;
        test_arb;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
